// File: rtl/cop_exc_pkg.sv
// Shared definitions for the coprocessor-0 exception block: operation codes,
// register numbers, STATUS/CAUSE bit positions, exception codes and reset
// values, plus the exception-vector selection helper.
package cop_exc_pkg;

  typedef enum logic [3:0] {
    COP_OP_NOP = 4'd0,
    COP_OP_MV  = 4'd1,
    COP_OP_SYS = 4'd2,
    COP_OP_BRK = 4'd3,
    COP_OP_RET = 4'd4,
    COP_OP_EN  = 4'd5,
    COP_OP_DIS = 4'd6
  } cop_op_e;

  localparam logic [4:0] REG_COUNT     = 5'd9;
  localparam logic [4:0] REG_COMPARE   = 5'd11;
  localparam logic [4:0] REG_STATUS    = 5'd12;
  localparam logic [4:0] REG_CAUSE     = 5'd13;
  localparam logic [4:0] REG_EPC       = 5'd14;
  localparam logic [4:0] REG_ERROR_EPC = 5'd30;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_ERL    = 2;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;

  localparam int CA_EXC_LO   = 2;
  localparam int CA_IP_LO    = 8;
  localparam int CA_IP_SW_LO = 8;
  localparam int CA_IP_HW_LO = 10;
  localparam int CA_TI       = 15;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;

  localparam logic [31:0] STATUS_RST  = 32'h0040_0004;
  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  // BEV selects the boot-ROM vector over the normal RAM vector.
  function automatic logic [31:0] exc_vector(input logic [31:0] status,
                                             input logic [31:0] boot_entry,
                                             input logic [31:0] exc_entry);
    return status[ST_BEV] ? boot_entry : exc_entry;
  endfunction

endpackage

// File: rtl/cop_exc_timer.sv
// cop_timer: free-running COUNT with COMPARE match detection.
// Only instantiated when COP_TIMER_EN is defined.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wr_count_i          mtc0 to COUNT this cycle (load instead of increment)
//   wr_compare_i        mtc0 to COMPARE this cycle (also clears pending)
//   wdata_i             write data
//   count_o, compare_o  current register values
//   pend_o              sticky timer interrupt pending (CAUSE[15])
module cop_timer
  import cop_exc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_count_i,
  input  logic        wr_compare_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        pend_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;

  always_comb begin
    count_d   = wr_count_i ? wdata_i : count_q + 32'd1;
    compare_d = wr_compare_i ? wdata_i : compare_q;
    // Sticky once matched; only a COMPARE write acknowledges it.
    pend_d    = wr_compare_i ? 1'b0 : (pend_q | (count_q == compare_q));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q   <= '0;
      compare_q <= COMPARE_RST;
      pend_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign pend_o    = pend_q;

endmodule

// File: rtl/cop_exc.sv
// cop_exc: coprocessor-0 register file and exception/interrupt sequencer.
// Handles mfc0/mtc0 access, syscall/break entry, interrupt entry, exception
// return and interrupt enable/disable, issuing a one-cycle fetch redirect.
// Optional feature macro: COP_TIMER_EN (COUNT increments every cycle and
// raises CAUSE[15] on COUNT==COMPARE; otherwise COUNT/COMPARE are plain
// registers and the timer pending bit is 0).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   reg_num, reg_sel          register select (reg_sel ignored)
//   in_data, reg_rd, reg_wr   mtc0 data and read/write qualifiers
//   cop_op, next_pc           operation code, return address for EPC
//   irq                       level-sensitive interrupt requests
//   out_data                  mfc0 read data (combinational)
//   redirect, redirect_pc     fetch-redirect pulse and target
//   irq_taken                 pulse accompanying an interrupt redirect
module cop_exc
  import cop_exc_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 6,
  parameter logic [31:0] EXC_ENTRY  = 32'h8000_0180,
  parameter logic [31:0] BOOT_ENTRY = 32'hBFC0_0380
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4:0]         reg_num,
  input  logic [2:0]         reg_sel,
  input  logic [31:0]        in_data,
  input  logic               reg_rd,
  input  logic               reg_wr,
  input  logic [3:0]         cop_op,
  input  logic [31:0]        next_pc,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        out_data,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic               irq_taken
);

  logic [31:0]        status_q, status_d;
  logic [4:0]         exc_q, exc_d;
  logic [1:0]         ip_sw_q, ip_sw_d;
  logic [NUM_IRQ-1:0] ip_hw_q;
  logic [31:0]        epc_q, epc_d;
  logic [31:0]        eepc_q, eepc_d;
  logic               redir_q, redir_d;
  logic [31:0]        rpc_q, rpc_d;
  logic               irqt_q, irqt_d;

  logic [31:0] count_val, compare_val, cause_val, vec, rd_val;
  logic        tmr_pend, is_mtc0, wr_count, wr_compare, int_req;

  logic unused_sel;
  assign unused_sel = ^reg_sel;

  assign is_mtc0    = (cop_op == COP_OP_MV) && reg_wr && !reg_rd;
  assign wr_count   = is_mtc0 && (reg_num == REG_COUNT);
  assign wr_compare = is_mtc0 && (reg_num == REG_COMPARE);

`ifdef COP_TIMER_EN
  cop_timer u_timer (
    .clk_i        (clk),
    .rst_i        (rst),
    .wr_count_i   (wr_count),
    .wr_compare_i (wr_compare),
    .wdata_i      (in_data),
    .count_o      (count_val),
    .compare_o    (compare_val),
    .pend_o       (tmr_pend)
  );
`else
  logic [31:0] count_q, compare_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= COMPARE_RST;
    end else begin
      if (wr_count)   count_q   <= in_data;
      if (wr_compare) compare_q <= in_data;
    end
  end

  assign count_val   = count_q;
  assign compare_val = compare_q;
  assign tmr_pend    = 1'b0;
`endif

  // CAUSE is assembled from its live fields; the timer bit shares IP7.
  always_comb begin
    cause_val = '0;
    cause_val[CA_EXC_LO +: 5]       = exc_q;
    cause_val[CA_IP_SW_LO +: 2]     = ip_sw_q;
    cause_val[CA_IP_HW_LO +: NUM_IRQ] = ip_hw_q;
    cause_val[CA_TI]                = cause_val[CA_TI] | tmr_pend;
  end

  assign vec = exc_vector(status_q, BOOT_ENTRY, EXC_ENTRY);

  // Interrupt decision always uses the pre-edge STATUS/CAUSE.
  assign int_req = status_q[ST_IE] && !status_q[ST_EXL] && !status_q[ST_ERL] &&
                   ((cause_val[CA_IP_LO +: 8] & status_q[ST_IM_LO +: 8]) != 8'h00);

  always_comb begin
    case (reg_num)
      REG_COUNT:     rd_val = count_val;
      REG_COMPARE:   rd_val = compare_val;
      REG_STATUS:    rd_val = status_q;
      REG_CAUSE:     rd_val = cause_val;
      REG_EPC:       rd_val = epc_q;
      REG_ERROR_EPC: rd_val = eepc_q;
      default:       rd_val = '0;
    endcase
    out_data = '0;
    if (cop_op == COP_OP_MV && reg_rd) begin
      out_data = rd_val;
    end else if (cop_op == COP_OP_EN || cop_op == COP_OP_DIS) begin
      out_data = status_q;
    end
  end

  always_comb begin
    status_d = status_q;
    exc_d    = exc_q;
    ip_sw_d  = ip_sw_q;
    epc_d    = epc_q;
    eepc_d   = eepc_q;
    redir_d  = 1'b0;
    rpc_d    = rpc_q;
    irqt_d   = 1'b0;

    if (is_mtc0) begin
      case (reg_num)
        REG_STATUS:    status_d = in_data;
        REG_CAUSE:     ip_sw_d  = in_data[CA_IP_SW_LO +: 2];
        REG_EPC:       epc_d    = in_data;
        REG_ERROR_EPC: eepc_d   = in_data;
        default:       ;
      endcase
    end

    case (cop_op)
      COP_OP_SYS, COP_OP_BRK: begin
        exc_d = (cop_op == COP_OP_SYS) ? EXC_SYS : EXC_BP;
        // A nested exception keeps the original return address.
        if (!status_q[ST_EXL]) epc_d = next_pc;
        status_d[ST_EXL] = 1'b1;
        redir_d = 1'b1;
        rpc_d   = vec;
      end
      COP_OP_RET: begin
        redir_d = 1'b1;
        if (status_q[ST_ERL]) begin
          rpc_d = eepc_q;
          status_d[ST_ERL] = 1'b0;
        end else begin
          rpc_d = epc_q;
          status_d[ST_EXL] = 1'b0;
        end
      end
      COP_OP_EN:  status_d[ST_IE] = 1'b1;
      COP_OP_DIS: status_d[ST_IE] = 1'b0;
      COP_OP_NOP: begin
        if (int_req) begin
          epc_d   = next_pc;
          exc_d   = EXC_INT;
          status_d[ST_EXL] = 1'b1;
          redir_d = 1'b1;
          rpc_d   = vec;
          irqt_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= STATUS_RST;
      exc_q    <= '0;
      ip_sw_q  <= '0;
      ip_hw_q  <= '0;
      epc_q    <= '0;
      eepc_q   <= '0;
      redir_q  <= 1'b0;
      rpc_q    <= '0;
      irqt_q   <= 1'b0;
    end else begin
      status_q <= status_d;
      exc_q    <= exc_d;
      ip_sw_q  <= ip_sw_d;
      ip_hw_q  <= irq;
      epc_q    <= epc_d;
      eepc_q   <= eepc_d;
      redir_q  <= redir_d;
      rpc_q    <= rpc_d;
      irqt_q   <= irqt_d;
    end
  end

  assign redirect    = redir_q;
  assign redirect_pc = rpc_q;
  assign irq_taken   = irqt_q;

endmodule

// File: tb/tb_cop_exc.sv
// Randomized scoreboard bench for cop_exc with a behavioural CP0 model.
module tb_cop_exc;
  import cop_exc_pkg::*;

  localparam logic [31:0] EXC_V  = 32'h8000_0180;
  localparam logic [31:0] BOOT_V = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg_num;
  logic [2:0]  reg_sel;
  logic [31:0] in_data;
  logic        reg_rd, reg_wr;
  logic [3:0]  cop_op;
  logic [31:0] next_pc;
  logic [5:0]  irq;
  logic [31:0] out_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        irq_taken;

  always #5 clk = ~clk;

  cop_exc #(.NUM_IRQ(6), .EXC_ENTRY(EXC_V), .BOOT_ENTRY(BOOT_V)) dut (
    .clk(clk), .rst(rst), .reg_num(reg_num), .reg_sel(reg_sel), .in_data(in_data),
    .reg_rd(reg_rd), .reg_wr(reg_wr), .cop_op(cop_op), .next_pc(next_pc), .irq(irq),
    .out_data(out_data), .redirect(redirect), .redirect_pc(redirect_pc), .irq_taken(irq_taken)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  typedef struct { int unsigned cyc; logic [31:0] pc; logic irq; } redir_t;
  typedef struct { int unsigned cyc; logic [31:0] val; } rdexp_t;
  redir_t rq[$];
  rdexp_t dq[$];

  // Reference architectural state.
  logic [31:0] m_status, m_epc, m_eepc, m_count, m_compare;
  logic [4:0]  m_exc;
  logic [1:0]  m_sw;
  logic [5:0]  m_irq;
  logic        m_tpend;
  logic [5:0]  cur_irq;

  function automatic logic [31:0] m_cause();
    return {16'h0, m_irq[5] | m_tpend, m_irq[4:0], m_sw, 1'b0, m_exc, 2'b00};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] n);
    case (n)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd30:   return m_eepc;
      default: return 32'h0;
    endcase
  endfunction

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_status = 32'h0040_0004; m_epc = '0; m_eepc = '0; m_count = '0;
    m_compare = 32'hFFFF_FFFF; m_exc = '0; m_sw = '0; m_irq = '0; m_tpend = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict its outcome, advance the model.
  task automatic step(input logic [3:0] op, input logic [4:0] rn, input logic rd,
                      input logic wr, input logic [31:0] d, input logic [31:0] pc);
    logic [31:0] vec, ns, nepc, neepc, ncount, ncomp, cause;
    logic [4:0]  nexc;
    logic [1:0]  nsw;
    logic        ntp, wr_ok;
    redir_t r;
    rdexp_t e;
    cop_op = op; reg_num = rn; reg_rd = rd; reg_wr = wr; in_data = d;
    next_pc = pc; irq = cur_irq; reg_sel = 3'($urandom);

    cause = m_cause();
    vec = m_status[22] ? BOOT_V : EXC_V;
    if (op == COP_OP_MV && rd) begin
      e.cyc = cyc; e.val = m_read(rn); dq.push_back(e);
    end else if (op == COP_OP_EN || op == COP_OP_DIS) begin
      e.cyc = cyc; e.val = m_status; dq.push_back(e);
    end

    ns = m_status; nepc = m_epc; neepc = m_eepc; ncount = m_count;
    ncomp = m_compare; nexc = m_exc; nsw = m_sw; ntp = m_tpend;
    r.cyc = cyc + 1; r.pc = 32'h0; r.irq = 1'b0;

    wr_ok = (op == COP_OP_MV) && wr && !rd;
    if (wr_ok) begin
      case (rn)
        5'd9:  ncount = d;
        5'd11: ncomp = d;
        5'd12: ns = d;
        5'd13: nsw = d[9:8];
        5'd14: nepc = d;
        5'd30: neepc = d;
        default: ;
      endcase
    end
`ifdef COP_TIMER_EN
    if (!(wr_ok && rn == 5'd9)) ncount = m_count + 32'd1;
    ntp = (wr_ok && rn == 5'd11) ? 1'b0 : (m_tpend || (m_count == m_compare));
`endif

    if (op == COP_OP_SYS || op == COP_OP_BRK) begin
      nexc = (op == COP_OP_SYS) ? 5'd8 : 5'd9;
      if (!m_status[1]) nepc = pc;
      ns[1] = 1'b1;
      r.pc = vec; rq.push_back(r);
    end else if (op == COP_OP_RET) begin
      if (m_status[2]) begin r.pc = m_eepc; ns[2] = 1'b0; end
      else begin r.pc = m_epc; ns[1] = 1'b0; end
      rq.push_back(r);
    end else if (op == COP_OP_EN) begin
      ns[0] = 1'b1;
    end else if (op == COP_OP_DIS) begin
      ns[0] = 1'b0;
    end else if (op == COP_OP_NOP) begin
      if (m_status[0] && !m_status[1] && !m_status[2] &&
          ((cause[15:8] & m_status[15:8]) != 8'h0)) begin
        nepc = pc; nexc = 5'd0; ns[1] = 1'b1;
        r.pc = vec; r.irq = 1'b1; rq.push_back(r);
      end
    end

    m_status = ns; m_epc = nepc; m_eepc = neepc; m_count = ncount;
    m_compare = ncomp; m_exc = nexc; m_sw = nsw; m_tpend = ntp; m_irq = cur_irq;
    @(posedge clk); #1;
  endtask

  task automatic mfc(input logic [4:0] rn);
    step(COP_OP_MV, rn, 1'b1, 1'b0, $urandom, $urandom);
  endtask

  task automatic mtc(input logic [4:0] rn, input logic [31:0] d);
    step(COP_OP_MV, rn, 1'b0, 1'b1, d, $urandom);
  endtask

  task automatic opx(input logic [3:0] op, input logic [31:0] pc);
    step(op, 5'($urandom), 1'b0, 1'b0, $urandom, pc);
  endtask

  // Monitor: compares DUT outputs against the scoreboard queues.
  logic [31:0] hold_pc = '0;
  initial begin
    redir_t r;
    rdexp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
          r = rq.pop_front();
          hold_pc = r.pc;
          check("redirect", {31'b0, redirect}, 32'd1);
          check("redirect_pc", redirect_pc, r.pc);
          check("irq_taken", {31'b0, irq_taken}, {31'b0, r.irq});
        end else begin
          check("redirect_idle", {31'b0, redirect}, 32'd0);
          check("irq_taken_idle", {31'b0, irq_taken}, 32'd0);
          check("redirect_pc_hold", redirect_pc, hold_pc);
        end
        if (dq.size() > 0 && dq[0].cyc == cyc) begin
          e = dq.pop_front();
          check("out_data", out_data, e.val);
        end else begin
          check("out_data_idle", out_data, 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  logic [31:0] st_tab [5];
  logic [4:0]  rn_tab [6];

  initial begin
    int unsigned r;
    logic [4:0]  rn;
    logic [31:0] d;
    st_tab = '{32'h0000_FC01, 32'h0040_FC01, 32'h0000_FC03, 32'h0000_FC05, 32'h0000_0301};
    rn_tab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd30};

    // Reset with a SYS and all interrupts presented: nothing may leak out.
    rst = 1'b1; cop_op = COP_OP_SYS; reg_num = 5'd12; reg_sel = '0; in_data = '0;
    reg_rd = 1'b1; reg_wr = 1'b0; next_pc = 32'h100; irq = 6'h3F; cur_irq = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Reset values, then SYS from boot state.
    mfc(12); mfc(13); mfc(14); mfc(30); mfc(9); mfc(11);
    opx(COP_OP_SYS, 32'h100); mfc(13); mfc(14); mfc(12);
    // Interrupt entry with irq[0].
    cur_irq = 6'h01; mtc(12, 32'h0000_FC01);
    opx(COP_OP_NOP, 32'h300);
    cur_irq = 6'h00; mfc(14); mfc(13); mfc(12);
    // Nested BRK keeps EPC; RET returns to it.
    opx(COP_OP_BRK, 32'h200); mfc(14); mfc(13);
    opx(COP_OP_RET, 32'h0); mfc(12);
    // Timer / COUNT handling.
    mtc(11, 32'd5); mtc(9, 32'd0);
    repeat (7) opx(COP_OP_NOP, 32'h500);
    mfc(13); mtc(11, 32'd5); mfc(13); mfc(9);
    mtc(12, 32'h0000_FC00);
    mtc(9, 32'hFFFF_FFFF); mfc(9); mfc(9);
    // SYS beats a pending interrupt in the same cycle.
    cur_irq = 6'h03; mtc(12, 32'h0000_FC01);
    opx(COP_OP_SYS, 32'h400); mfc(13); mfc(14);
    cur_irq = 6'h00;
    // Enable/disable, unknown op, RET from ERROR, software interrupt.
    opx(COP_OP_DIS, 32'h0); opx(COP_OP_EN, 32'h0); opx(4'hB, 32'h0); mfc(12);
    mtc(30, 32'h0000_1234); mtc(12, 32'h0000_0006); opx(COP_OP_RET, 32'h0); mfc(12);
    opx(COP_OP_RET, 32'h0); mfc(12); opx(COP_OP_RET, 32'h0);
    mtc(12, 32'h0000_0301); mtc(13, 32'hFFFF_FFFF); mfc(13);
    opx(COP_OP_NOP, 32'h600); mfc(14); mfc(13);
    mtc(13, 32'h0); mtc(12, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 3) == 0) cur_irq = 6'($urandom);
      r = $urandom_range(0, 15);
      if (r < 5) begin
        opx(COP_OP_NOP, $urandom & 32'hFFFF_FFFC);
      end else if (r < 10) begin
        rn = ($urandom_range(0, 7) == 0) ? 5'($urandom) : rn_tab[$urandom_range(0, 5)];
        d = (rn == 5'd12 && $urandom_range(0, 3) != 0) ? st_tab[$urandom_range(0, 4)] : $urandom;
        step(COP_OP_MV, rn, 1'($urandom), 1'($urandom), d, $urandom);
      end else if (r == 10) opx(COP_OP_SYS, $urandom & 32'hFFFF_FFFC);
      else if (r == 11) opx(COP_OP_BRK, $urandom & 32'hFFFF_FFFC);
      else if (r == 12) opx(COP_OP_RET, 32'h0);
      else if (r == 13) opx(COP_OP_EN, 32'h0);
      else if (r == 14) opx(COP_OP_DIS, 32'h0);
      else opx(4'($urandom_range(7, 15)), $urandom);
    end

    // Final cycle: unknown op so nothing new is predicted.
    cop_op = 4'hF; reg_rd = 1'b0; reg_wr = 1'b0;
    @(negedge clk); #1;
    mon_en = 1'b0;
    vectors++;
    if (rq.size() + dq.size() != 0) begin
      miscompares++;
      $display("FAIL drain got=%0d pending expected=0", rq.size() + dq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cop_exc.md
COP_EXC -- requirements
Module: cop_exc

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 6: external interrupt lines, 1..6, mapped to CAUSE[10+NUM_IRQ-1:10].
REQ-002 SHALL have parameter EXC_ENTRY, default 32'h80000180: exception vector when STATUS.BEV=0.
REQ-003 SHALL have parameter BOOT_ENTRY, default 32'hBFC00380: exception vector when STATUS.BEV=1.
REQ-004 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports reg_num in 5, reg_sel in 3 (ignored), in_data in 32, reg_rd in 1, reg_wr in 1: mfc0/mtc0 access.
REQ-007 SHALL have ports cop_op in 4 (shared COP_OP_* codes) and next_pc in 32 (address recorded as EPC).
REQ-008 SHALL have port irq  in  NUM_IRQ  level-sensitive interrupt requests.
REQ-009 SHALL have ports out_data out 32 (mfc0 read data) and redirect out 1 (one-cycle fetch-redirect pulse).
REQ-010 SHALL have ports redirect_pc out 32 (target valid while redirect=1) and irq_taken out 1 (pulse with an interrupt redirect).

Function
REQ-011 Registers: COUNT(9), COMPARE(11), STATUS(12), CAUSE(13), EPC(14), ERROR_EPC(30); other numbers read 0, writes dropped.
REQ-012 out_data combinational: current register value when cop_op=MV and reg_rd=1, else 0; RAW on same register returns the pre-write value.
REQ-013 mtc0 (MV, reg_wr=1, reg_rd=0) updates the register at the edge ending the cycle; CAUSE writable only in bits [9:8].
REQ-014 State from STATUS: NORMAL (EXL=0, ERL=0), EXCEPTION (EXL=1, ERL=0), ERROR (ERL=1).
REQ-015 SYS/BRK: CAUSE.ExcCode <= 8/9; redirect to vector one cycle later; state -> EXCEPTION.
REQ-016 SYS/BRK in NORMAL: EPC <= next_pc; already EXL=1: EPC kept, ExcCode still updated.
REQ-017 Interrupt taken when cop_op=NOP, IE=1, state NORMAL, (CAUSE.IP & STATUS.IM) != 0: EPC <= next_pc, ExcCode <= 0, EXL <= 1, redirect+irq_taken next cycle.
REQ-018 CAUSE[10+i] <= irq[i] every cycle (registered, no latching); software IP[9:8] participate in REQ-017.
REQ-019 RET: ERROR -> redirect ERROR_EPC, ERL <= 0; else redirect EPC, EXL <= 0; RET in NORMAL redirects EPC, STATUS unchanged.
REQ-020 EN/DIS: IE <= 1/0; out_data = STATUS before the change.
REQ-021 redirect high exactly one cycle after the accepting cycle; redirect_pc holds last target otherwise.
REQ-022 Priority same cycle: SYS/BRK/RET over interrupt; mtc0 STATUS and pending interrupt: interrupt evaluated on old STATUS.
REQ-023 Unknown cop_op: no state change, no redirect.

Reset
REQ-024 On rst at a clock edge: STATUS=32'h00400004 (BEV=1, ERL=1, IE=0), CAUSE=0, EPC=0, ERROR_EPC=0, COUNT=0, COMPARE=32'hFFFFFFFF.
REQ-025 On rst: redirect=0, irq_taken=0, redirect_pc=0; any redirect pending from the prior cycle is cancelled.

Configuration
REQ-026 Macro COP_TIMER_EN defined: COUNT +1 every cycle (wraps 32'hFFFFFFFF->0), CAUSE[15] set when COUNT==COMPARE, cleared only by mtc0 COMPARE.
REQ-027 COP_TIMER_EN defined: mtc0 COUNT loads in_data instead of incrementing that cycle.
REQ-028 COP_TIMER_EN absent: COUNT changes only via mtc0, CAUSE[15] tied 0.

Structure
REQ-029 Shared package/header holds COP_OP_* codes, register numbers, STATUS/CAUSE bit positions, ExcCode values (INT=0, SYS=8, BP=9).
REQ-030 Optional sub-module cop_timer (COUNT/COMPARE/timer pending), instantiated only under COP_TIMER_EN.

Verification
REQ-031 rst, then mfc0 12 -> out_data=32'h00400004; SYS with next_pc=32'h100 -> next cycle redirect=1, redirect_pc=32'hBFC00380.
REQ-032 mtc0 12<=32'h0000FC01, irq[0]=1, NOP -> next cycle redirect=1, irq_taken=1, EPC=next_pc, CAUSE.ExcCode=0, EXL=1.
REQ-033 During EXL=1: BRK with next_pc=32'h200 -> EPC unchanged, ExcCode=9; RET -> redirect_pc=old EPC, EXL=0.
REQ-034 With COP_TIMER_EN: COMPARE<=5, COUNT<=0 -> CAUSE[15]=1 after COUNT reaches 5; mtc0 COMPARE clears it.
REQ-035 COUNT<=32'hFFFFFFFF -> next cycle COUNT=0; SYS and irq same cycle -> ExcCode=8, irq_taken=0.
